vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port synchronous frame-buffer RAM between three masters: the video scan-out fetcher, the host (Pi-side) port, and an internal plane-fill engine.
- Frame buffer holds two bitplanes (red field, green field), each 240 lines x 64 bytes, with 1 byte per 8-pixel character.
- The scan-out fetcher issues one byte fetch per character time and has absolute priority. The host and fill engine get all remaining pixel-clock slots.

Parameters:
- ADDR_W, 15, RAM byte address width; the plane select is bit ADDR_W-1.
- DATA_W, 8, RAM data width (one character cell).
- PLANE_WORDS, 15360, bytes per plane, filled by a fill operation; overridable for simulation.

Ports:
- clk_pixel  in  1  pixel clock (19.6608 MHz); all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  scan-out fetch request, 1-cycle pulse, at most one per 8 cycles
- fetch_addr  in  ADDR_W  scan-out byte address, valid with fetch_req
- fetch_data  out  DATA_W  fetched byte
- fetch_valid  out  1  1-cycle pulse, fetch_data valid
- host_req  in  1  host access request, held until accepted
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host byte address
- host_wdata  in  DATA_W  host write data
- host_ready  out  1  host request accepted this cycle when host_req=1
- host_rdata  out  DATA_W  host read data
- host_rvalid  out  1  1-cycle pulse, host_rdata valid
- fill_start  in  1  1-cycle pulse, start plane fill
- fill_plane  in  1  plane to fill (0 = red, 1 = green), sampled with fill_start
- fill_value  in  DATA_W  fill byte, sampled with fill_start
- fill_busy  out  1  fill in progress
- fill_done  out  1  1-cycle pulse at fill completion
- ram_addr  out  ADDR_W  registered RAM address
- ram_we  out  1  registered RAM write enable
- ram_wdata  out  DATA_W  registered RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address is presented

Behaviour:
- Reset: ram_addr=0, ram_we=0, ram_wdata=0, fetch_valid=0, fetch_data=0, host_rvalid=0, host_rdata=0, fill_busy=0, fill_done=0.
- Reset also clears the read-tag pipeline and aborts any fill, returning the FSM to IDLE.
- A fetch or host read in flight at reset produces no valid pulse.
- Slot decision is made in cycle N from the inputs. The winner's command is registered onto ram_* for cycle N+1. Idle slots drive ram_we=0 and hold ram_addr.
- Priority: fetch_req > fill engine (FSM state FILL) > host.
- host_ready = !reset && !fetch_req && state==IDLE. It is combinational.
- Reads: RAM returns data in cycle N+2. The arbiter registers it, so fetch_valid (or host_rvalid) is high in cycle N+3. Latency is fixed at 3 cycles.
- A 2-entry tag shift register (none/fetch/host) routes returning data to the correct master.
- Host writes give no response; host_ready is the acknowledgement.
- fetch_req is never stalled or dropped. A fetch_req arriving inside 8 cycles of the previous one is still served; this is a protocol violation and needs no check.
- FSM states:
  - IDLE: on fill_start, latch the plane and value, fill_ptr=0, go to FILL next cycle.
  - FILL: each cycle without fetch_req, issue a write of fill_value to {fill_plane, fill_ptr} and increment fill_ptr.
  - When the write at fill_ptr==PLANE_WORDS-1 issues, go to DONE.
  - DONE: fill_done=1 for one cycle, then IDLE.
- fill_busy=1 in FILL and DONE.
- fill_start in FILL or DONE is ignored.
- fill_start in IDLE in the same cycle as an accepted host_req: the host access is issued that cycle; FILL starts next cycle.
- Fill address = fill_plane * 2^(ADDR_W-1) + fill_ptr. fill_ptr is ADDR_W-1 bits wide and never wraps past PLANE_WORDS-1.
- Host addresses are passed through unchecked. Addresses at or beyond PLANE_WORDS within a plane are legal RAM locations.

Test Plan:
- Reset, then host write 0xA5 to 0x0040, then host read 0x0040: host_ready=1 on both requests; ram_we=1 with ram_addr=0x0040 the next cycle; host_rvalid with host_rdata=0xA5 exactly 3 cycles after the read is accepted.
- fetch_req (addr 0x4000) and host_req read (addr 0x0001) asserted in the same cycle: host_ready=0 that cycle, host accepted the next cycle. fetch_valid at +3 with the byte at 0x4000; host_rvalid at +4 with the byte at 0x0001; no crossed data.
- PLANE_WORDS=16, fill_start plane=1 value=0x3C, with fetch_req every 8 cycles: writes hit 0x4000..0x400F in order with no skips; fetch slots are preserved; fill_done pulses once; host_ready=0 throughout FILL and DONE.
- fill_start asserted again mid-fill: ignored; the write count stays 16.
- reset asserted 1 cycle after a fetch issue and mid-fill: no fetch_valid, fill_busy=0 the next cycle; a subsequent host read returns correct data.
- Back-to-back host reads every cycle with no fetches: one accepted per cycle; host_rvalid pulses in the same order at +3 each.

Source files
------------

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port synchronous frame-buffer RAM between three masters:
//   - scan-out fetcher (absolute priority, never stalled)
//   - plane-fill engine (writes one whole plane with a constant byte)
//   - host port (gets every slot left over by the other two)
//
// The slot decision is made combinationally in cycle N. The winner's command
// is registered onto ram_* for cycle N+1. The RAM answers in cycle N+2, and
// the answer is registered again so that fetch_valid / host_rvalid are high
// in cycle N+3. A short tag pipeline travels alongside the RAM command so
// that returning read data reaches the master that asked for it.
//
// Ports:
//   clk_pixel   pixel clock, every register is on its rising edge
//   reset       synchronous active-high reset
//   fetch_*     scan-out fetch request / address / returned byte + valid
//   host_*      host request handshake (req/ready), write data, read data
//   fill_*      fill start pulse, plane and value, busy level, done pulse
//   ram_*       registered RAM command (addr/we/wdata) and RAM read data
// ---------------------------------------------------------------------------
module vram_arbiter #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 8,
    parameter int PLANE_WORDS = 15360
) (
    input  logic              clk_pixel,
    input  logic              reset,
    // scan-out fetcher
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    // host port
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    // plane-fill engine control
    input  logic              fill_start,
    input  logic              fill_plane,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    // RAM side
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    // Offset within a plane; the top address bit selects the plane.
    localparam int PTR_W     = ADDR_W - 1;
    localparam int TAG_DEPTH = 2;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PLANE_WORDS - 1);

    // Read tags: who owns the read travelling through the RAM pipeline.
    localparam logic [1:0] TAG_NONE  = 2'd0;
    localparam logic [1:0] TAG_FETCH = 2'd1;
    localparam logic [1:0] TAG_HOST  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_reg, state_next;
    logic [PTR_W-1:0]  fill_ptr_reg, fill_ptr_next;
    logic              fill_plane_reg, fill_plane_next;
    logic [DATA_W-1:0] fill_value_reg, fill_value_next;

    logic [ADDR_W-1:0] ram_addr_reg;
    logic              ram_we_reg;
    logic [DATA_W-1:0] ram_wdata_reg;

    logic [1:0]        tag_reg [TAG_DEPTH];
    logic [1:0]        tag_in  [TAG_DEPTH];
    logic [1:0]        tag_out;

    logic              fetch_valid_reg;
    logic [DATA_W-1:0] fetch_data_reg;
    logic              host_rvalid_reg;
    logic [DATA_W-1:0] host_rdata_reg;

    // ------------------------------------------------------------------
    // Slot arbitration
    // ------------------------------------------------------------------
    logic              host_go;
    logic              fill_write;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [1:0]        cmd_tag;

    // The host is only served while the fill engine is idle and no fetch
    // claims the slot. Reset is folded in so the host never sees an
    // acknowledge for a request that the reset would throw away.
    assign host_ready = !reset && !fetch_req && (state_reg == ST_IDLE);
    assign host_go    = host_req && host_ready;
    assign fill_write = !fetch_req && (state_reg == ST_FILL);

    always_comb begin
        // Idle slot: no write, address and write data hold their last value.
        cmd_we    = 1'b0;
        cmd_addr  = ram_addr_reg;
        cmd_wdata = ram_wdata_reg;
        cmd_tag   = TAG_NONE;
        if (fetch_req) begin
            cmd_addr = fetch_addr;
            cmd_tag  = TAG_FETCH;
        end else if (fill_write) begin
            cmd_we    = 1'b1;
            cmd_addr  = {fill_plane_reg, fill_ptr_reg};
            cmd_wdata = fill_value_reg;
        end else if (host_go) begin
            cmd_we   = host_we;
            cmd_addr = host_addr;
            if (host_we) begin
                cmd_wdata = host_wdata;
            end else begin
                cmd_tag = TAG_HOST;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fill FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        fill_ptr_next   = fill_ptr_reg;
        fill_plane_next = fill_plane_reg;
        fill_value_next = fill_value_reg;
        case (state_reg)
            ST_IDLE: begin
                // A host access accepted in this same cycle still issues;
                // the fill begins writing in the next cycle.
                if (fill_start) begin
                    fill_plane_next = fill_plane;
                    fill_value_next = fill_value;
                    fill_ptr_next   = '0;
                    state_next      = ST_FILL;
                end
            end
            ST_FILL: begin
                // A fetch steals the slot; the pointer only moves when the
                // write actually went out, so no location is skipped.
                if (fill_write) begin
                    if (fill_ptr_reg == PTR_LAST) begin
                        state_next = ST_DONE;
                    end else begin
                        fill_ptr_next = fill_ptr_reg + PTR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign fill_busy = (state_reg != ST_IDLE);
    assign fill_done = (state_reg == ST_DONE);

    // ------------------------------------------------------------------
    // Tag pipeline inputs: stage 0 takes the new command's tag, every
    // later stage takes the previous one. The last stage lines up with
    // ram_rdata.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < TAG_DEPTH; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_in[gi] = cmd_tag;
            end else begin : g_shift
                assign tag_in[gi] = tag_reg[gi-1];
            end
        end
    endgenerate

    assign tag_out = tag_reg[TAG_DEPTH-1];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            fill_ptr_reg    <= '0;
            fill_plane_reg  <= 1'b0;
            fill_value_reg  <= '0;
            ram_addr_reg    <= '0;
            ram_we_reg      <= 1'b0;
            ram_wdata_reg   <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_reg[i] <= TAG_NONE;
            end
            fetch_valid_reg <= 1'b0;
            fetch_data_reg  <= '0;
            host_rvalid_reg <= 1'b0;
            host_rdata_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            fill_ptr_reg    <= fill_ptr_next;
            fill_plane_reg  <= fill_plane_next;
            fill_value_reg  <= fill_value_next;
            ram_addr_reg    <= cmd_addr;
            ram_we_reg      <= cmd_we;
            ram_wdata_reg   <= cmd_wdata;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_reg[i] <= tag_in[i];
            end
            fetch_valid_reg <= (tag_out == TAG_FETCH);
            host_rvalid_reg <= (tag_out == TAG_HOST);
            // Data registers hold between reads so a master sees a stable
            // byte after its valid pulse.
            if (tag_out == TAG_FETCH) begin
                fetch_data_reg <= ram_rdata;
            end
            if (tag_out == TAG_HOST) begin
                host_rdata_reg <= ram_rdata;
            end
        end
    end

    assign ram_addr    = ram_addr_reg;
    assign ram_we      = ram_we_reg;
    assign ram_wdata   = ram_wdata_reg;
    assign fetch_valid = fetch_valid_reg;
    assign fetch_data  = fetch_data_reg;
    assign host_rvalid = host_rvalid_reg;
    assign host_rdata  = host_rdata_reg;

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
//
// Directed bench for vram_arbiter with a behavioural single-port RAM.
// Stimulus tasks push the expected read response (owner, byte, due cycle)
// into a queue; a separate monitor pops and compares whenever fetch_valid
// or host_rvalid is seen. RAM contents start as pat(addr); expected bytes
// are either pat() values or bytes the bench itself wrote earlier.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int PW     = 16;

    logic              clk_pixel = 1'b0;
    logic              reset;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ready;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;
    logic              fill_start;
    logic              fill_plane;
    logic [DATA_W-1:0] fill_value;
    logic              fill_busy;
    logic              fill_done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PLANE_WORDS(PW)
    ) dut (
        .clk_pixel(clk_pixel), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_data(fetch_data), .fetch_valid(fetch_valid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .fill_start(fill_start), .fill_plane(fill_plane),
        .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Initial RAM content: pat(a) = a[7:0] ^ a[14:8] ^ 0x5B
    //   0x0001 -> 0x5A   0x0002 -> 0x59   0x4000 -> 0x1B   0x7FFF -> 0xDB
    function automatic logic [7:0] pat(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5B;
    endfunction

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = pat(15'(i));
    end
    always @(posedge clk_pixel) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk_pixel) cyc <= cyc + 1;

    typedef struct {
        bit         is_host;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t        exp_q[$];
    logic [22:0] wlog[$];      // {addr, data} of every RAM write seen
    int          done_cnt = 0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    // Monitor: read responses, host lock-out during fill, write log.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_pixel);
            if (fetch_valid && host_rvalid) begin
                chk("both_valid", 32'(1), 32'(0));
            end else if (fetch_valid || host_rvalid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", {31'd0, host_rvalid}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    $display("resp %s data=%02h cycle=%0d", host_rvalid ? "host " : "fetch",
                             host_rvalid ? host_rdata : fetch_data, cyc);
                    chk("resp_owner", {31'd0, host_rvalid}, {31'd0, e.is_host});
                    chk("resp_data", {24'd0, host_rvalid ? host_rdata : fetch_data}, {24'd0, e.data});
                    chk("resp_latency", 32'(cyc), 32'(e.due));
                end
            end
            if (fill_busy) chk("host_ready_in_fill", {31'd0, host_ready}, 32'd0);
            if (ram_we) wlog.push_back({ram_addr, ram_wdata});
            if (fill_done) done_cnt++;
        end
    end

    task automatic fetch(input logic [14:0] a, input logic [7:0] d, input bit push);
        fetch_req  = 1'b1;
        fetch_addr = a;
        @(negedge clk_pixel);
        if (push) exp_q.push_back('{1'b0, d, cyc + 3});
        $display("fetch addr=%04h cycle=%0d", a, cyc);
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic host_access(input bit we, input logic [14:0] a, input logic [7:0] d,
                               output int acc_cyc);
        bit acc = 0;
        acc_cyc    = -1;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge clk_pixel);
            if (host_ready) begin
                acc     = 1;
                acc_cyc = cyc;
                if (!we) exp_q.push_back('{1'b1, d, cyc + 3});
                $display("host %s addr=%04h data=%02h cycle=%0d", we ? "wr" : "rd", a, d, cyc);
            end
            tick();
        end
        host_req = 1'b0;
        if (!acc) chk("host_accept_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int a0, a1, fc, b, d0;
    int acc_c[5];
    logic [14:0] rd_addr[5];
    logic [7:0]  rd_data[5];

    initial begin
        reset = 1'b1; fetch_req = 0; fetch_addr = '0; host_req = 0; host_we = 0;
        host_addr = '0; host_wdata = '0; fill_start = 0; fill_plane = 0; fill_value = '0;
        repeat (3) tick();
        @(negedge clk_pixel);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_wdata", 32'(ram_wdata), 0);
        chk("rst_fetch_valid", 32'(fetch_valid), 0);
        chk("rst_fetch_data", 32'(fetch_data), 0);
        chk("rst_host_rvalid", 32'(host_rvalid), 0);
        chk("rst_host_rdata", 32'(host_rdata), 0);
        chk("rst_fill_busy", 32'(fill_busy), 0);
        chk("rst_fill_done", 32'(fill_done), 0);
        chk("rst_host_ready", 32'(host_ready), 0);
        tick();
        reset = 1'b0;
        tick();

        // 1: host write 0xA5 @0x0040, then read it back
        fc = cyc;
        host_access(1'b1, 15'h0040, 8'hA5, a0);
        chk("wr_accept_cycle", 32'(a0), 32'(fc));
        chk("wr_ram_we", 32'(ram_we), 1);
        chk("wr_ram_addr", 32'(ram_addr), 32'h0040);
        chk("wr_ram_wdata", 32'(ram_wdata), 32'hA5);
        fc = cyc;
        host_access(1'b0, 15'h0040, 8'hA5, a0);
        chk("rd_accept_cycle", 32'(a0), 32'(fc));
        repeat (5) tick();

        // 2: fetch and host read in the same cycle
        fc = cyc;
        fork
            fetch(15'h4000, 8'h1B, 1'b1);
            host_access(1'b0, 15'h0001, 8'h5A, a1);
        join
        chk("host_deferred_by_fetch", 32'(a1), 32'(fc + 1));
        repeat (6) tick();
        chk("queue_drained_2", 32'(exp_q.size()), 0);

        // 3: fill plane 1 with 0x3C, fetches every 8 cycles, second start ignored
        wlog.delete();
        d0 = done_cnt;
        fill_start = 1'b1; fill_plane = 1'b1; fill_value = 8'h3C;
        tick();
        fill_start = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    fetch(15'h0100 + 15'(i * 8), pat(15'h0100 + 15'(i * 8)), 1'b1);
                    repeat (7) tick();
                end
            end
            begin
                repeat (4) tick();
                fill_start = 1'b1; fill_plane = 1'b0; fill_value = 8'h77;
                tick();
                fill_start = 1'b0;
            end
        join
        for (int t = 0; t < 100 && fill_busy; t++) tick();
        chk("fill_finished", 32'(fill_busy), 0);
        repeat (4) tick();
        chk("fill_write_count", 32'(wlog.size()), 16);
        for (int i = 0; i < 16 && i < wlog.size(); i++) begin
            chk("fill_write_addr", 32'(wlog[i][22:8]), 32'h4000 + 32'(i));
            chk("fill_write_data", 32'(wlog[i][7:0]), 32'h3C);
        end
        chk("fill_done_pulses", 32'(done_cnt - d0), 1);
        chk("queue_drained_3", 32'(exp_q.size()), 0);

        // 4: reset one cycle after a fetch issue, in the middle of a fill
        fill_start = 1'b1; fill_plane = 1'b1; fill_value = 8'hC3;
        tick();
        fill_start = 1'b0;
        tick();
        tick();
        b = cyc;
        fetch(15'h0200, 8'h00, 1'b0);   // response must never appear
        reset = 1'b1;
        @(negedge clk_pixel);
        chk("host_ready_in_reset", 32'(host_ready), 0);
        tick();
        reset = 1'b0;
        @(negedge clk_pixel);
        chk("fill_busy_after_reset", 32'(fill_busy), 0);
        tick();
        @(negedge clk_pixel);
        chk("no_fetch_valid_b3", 32'(fetch_valid), 0);
        tick();
        @(negedge clk_pixel);
        chk("no_fetch_valid_b4", 32'(fetch_valid), 0);
        tick();
        host_access(1'b0, 15'h0040, 8'hA5, a0);
        host_access(1'b0, 15'h4001, 8'hC3, a0);   // written before the reset
        host_access(1'b0, 15'h4002, 8'h3C, a0);   // aborted: still from test 3
        repeat (6) tick();
        chk("queue_drained_4", 32'(exp_q.size()), 0);

        // 5: back-to-back host reads, one per cycle
        rd_addr[0] = 15'h0040; rd_data[0] = 8'hA5;
        rd_addr[1] = 15'h0001; rd_data[1] = 8'h5A;
        rd_addr[2] = 15'h0002; rd_data[2] = 8'h59;
        rd_addr[3] = 15'h7FFF; rd_data[3] = 8'hDB;
        rd_addr[4] = 15'h400F; rd_data[4] = 8'h3C;
        for (int i = 0; i < 5; i++) host_access(1'b0, rd_addr[i], rd_data[i], acc_c[i]);
        for (int i = 1; i < 5; i++) chk("b2b_accept_cycle", 32'(acc_c[i]), 32'(acc_c[0] + i));
        repeat (8) tick();
        chk("queue_drained_5", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
